ddr_rx_capture: RTL and testbench

DDR_RX_CAPTURE -- requirements
Module: ddr_rx_capture

---
 rtl/ddr_rx_capture.sv | 145 ++++++++++++++
 tb/tb_ddr_rx_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rx_capture.sv
// DDR receive capture: samples din on both clk edges, pairs the beats per the
// latched phase alignment and packs GEAR pairs per word for a counted burst.
module ddr_rx_capture #(
  parameter int WIDTH    = 8,
  parameter int GEAR     = 2,
  parameter int CNT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      capture_start,
  input  logic [CNT_BITS-1:0]       capture_len,
  input  logic                      phase_sel,
  output logic [WIDTH-1:0]          dout_ris,
  output logic [WIDTH-1:0]          dout_fal,
  output logic [2*WIDTH*GEAR-1:0]   dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = PW * GEAR;

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t                state, state_next;
  logic [WIDTH-1:0]      rise_p0, fal_p0, fal_p2;
  logic [PW-1:0]         pair;
  logic [DW-1:0]         gbox, gbox_shift;
  logic [DW+PW-1:0]      gcat;
  logic [2:0]            gcnt;
  logic [CNT_BITS-1:0]   wcnt, len_q;
  logic                  phase_q, first;
  logic                  load, clr_first, shift, word_end, finish;

  // Stage p0: falling-edge capture
  always_ff @(negedge clk or posedge reset) begin
    if (reset) fal_p0 <= '0;
    else       fal_p0 <= din;
  end

  // Stage p0/p1/p2: rising capture, same-edge realignment, delayed fall beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_p0  <= '0;
      dout_ris <= '0;
      dout_fal <= '0;
      fal_p2   <= '0;
    end else begin
      rise_p0  <= din;
      dout_ris <= rise_p0;
      dout_fal <= fal_p0;
      fal_p2   <= dout_fal;
    end
  end

  // Phase 1 pairs a fall beat with the following rise beat, one cycle older.
  assign pair       = phase_q ? {fal_p2, dout_ris} : {dout_ris, dout_fal};
  assign gcat       = {gbox, pair};
  assign gbox_shift = gcat[DW-1:0];
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clr_first  = 1'b0;
    shift      = 1'b0;
    word_end   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (capture_start) begin
          load       = 1'b1;
          state_next = phase_sel ? ALIGN : RUN;
        end
      end
      ALIGN: begin
        if (len_q == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // The first RUN edge only primes the pair pipeline.
        if (first) begin
          if (len_q == '0) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            clr_first = 1'b1;
          end
        end else begin
          shift = 1'b1;
          if (gcnt == 3'(GEAR - 1)) begin
            word_end = 1'b1;
            if (wcnt == len_q - CNT_BITS'(1)) begin
              finish     = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      first      <= 1'b0;
      gcnt       <= '0;
      wcnt       <= '0;
      len_q      <= '0;
      phase_q    <= 1'b0;
      gbox       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      dout_valid <= word_end;
      done       <= finish;
      if (load) begin
        len_q   <= capture_len;
        phase_q <= phase_sel;
        first   <= 1'b1;
        gcnt    <= '0;
        wcnt    <= '0;
      end
      if (clr_first) first <= 1'b0;
      if (shift) begin
        gbox <= gbox_shift;
        gcnt <= word_end ? 3'd0 : gcnt + 3'd1;
      end
      if (word_end) begin
        dout <= gbox_shift;
        wcnt <= wcnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr_rx_capture.sv
// Directed bench for ddr_rx_capture: an 8-bit/GEAR=2 instance and a
// 4-bit/GEAR=1 instance sharing clock and reset.
module tb_ddr_rx_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din8, len8, ris8, fal8;
  logic        start8, ph8, valid8, busy8, done8;
  logic [31:0] dout8;
  logic [3:0]  din4, ris4, fal4;
  logic [7:0]  len4, dout4;
  logic        start4, ph4, valid4, busy4, done4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ddr_rx_capture #(.WIDTH(8), .GEAR(2), .CNT_BITS(8)) dut (
    .clk(clk), .reset(reset), .din(din8), .capture_start(start8),
    .capture_len(len8), .phase_sel(ph8), .dout_ris(ris8), .dout_fal(fal8),
    .dout(dout8), .dout_valid(valid8), .busy(busy8), .done(done8)
  );

  ddr_rx_capture #(.WIDTH(4), .GEAR(1), .CNT_BITS(8)) dut4 (
    .clk(clk), .reset(reset), .din(din4), .capture_start(start4),
    .capture_len(len4), .phase_sel(ph4), .dout_ris(ris4), .dout_fal(fal4),
    .dout(dout4), .dout_valid(valid4), .busy(busy4), .done(done4)
  );

  // One clk cycle: rv before the posedge, fv before the negedge; returns
  // just after the negedge so outputs reflect the posedge just taken.
  task automatic tick(input logic [7:0] rv, input logic [7:0] fv,
                      input logic s8, input logic s4);
    din8 = rv; din4 = rv[3:0]; start8 = s8; start4 = s4;
    @(posedge clk); #1;
    start8 = 1'b0; start4 = 1'b0; din8 = fv; din4 = fv[3:0];
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; #1 reset = 1'b1; #1;
    total_cnt++;
    if ({dout8, valid8, busy8, done8, ris8, fal8} !== 51'd0) $display("FAIL reset8: got %h want 0", {dout8, valid8, busy8, done8, ris8, fal8});
    else pass_cnt++;
    total_cnt++;
    if ({dout4, valid4, busy4, done4, ris4, fal4} !== 19'd0) $display("FAIL reset4: got %h want 0", {dout4, valid4, busy4, done4, ris4, fal4});
    else pass_cnt++;
    @(negedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_phase0();
    logic exp_v;
    len8 = 8'd2; ph8 = 1'b0;
    for (int n = 0; n < 7; n++) begin
      tick(8'(16 + 2*n), 8'(17 + 2*n), n == 0, 1'b0);
      exp_v = (n == 3 || n == 5);
      total_cnt++;
      if (valid8 !== exp_v) $display("FAIL p0_valid n=%0d: got %b want %b", n, valid8, exp_v);
      else pass_cnt++;
      total_cnt++;
      if (done8 !== (n == 5)) $display("FAIL p0_done n=%0d: got %b want %b", n, done8, n == 5);
      else pass_cnt++;
      total_cnt++;
      if (busy8 !== (n < 5)) $display("FAIL p0_busy n=%0d: got %b want %b", n, busy8, n < 5);
      else pass_cnt++;
      if (n == 3 || n == 4) begin
        total_cnt++;
        if (dout8 !== 32'h10111213) $display("FAIL p0_word0 n=%0d: got %h want 10111213", n, dout8);
        else pass_cnt++;
      end
      if (n == 5) begin
        total_cnt++;
        if (dout8 !== 32'h14151617) $display("FAIL p0_word1: got %h want 14151617", dout8);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_phase1();
    logic exp_v;
    len8 = 8'd2; ph8 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick(8'(16 + 2*n), 8'(17 + 2*n), n == 0, 1'b0);
      ph8 = 1'b0;
      exp_v = (n == 4 || n == 6);
      total_cnt++;
      if (valid8 !== exp_v) $display("FAIL p1_valid n=%0d: got %b want %b", n, valid8, exp_v);
      else pass_cnt++;
      total_cnt++;
      if (done8 !== (n == 6)) $display("FAIL p1_done n=%0d: got %b want %b", n, done8, n == 6);
      else pass_cnt++;
      if (n == 4) begin
        total_cnt++;
        if (dout8 !== 32'h11121314) $display("FAIL p1_word0: got %h want 11121314", dout8);
        else pass_cnt++;
      end
      if (n == 6) begin
        total_cnt++;
        if (dout8 !== 32'h15161718) $display("FAIL p1_word1: got %h want 15161718", dout8);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_len0();
    len8 = 8'd0; ph8 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick(8'h40, 8'h41, n == 0, 1'b0);
      total_cnt++;
      if (valid8 !== 1'b0) $display("FAIL len0_valid n=%0d: got %b want 0", n, valid8);
      else pass_cnt++;
      total_cnt++;
      if (done8 !== (n == 1)) $display("FAIL len0_done n=%0d: got %b want %b", n, done8, n == 1);
      else pass_cnt++;
      total_cnt++;
      if (busy8 !== (n == 0)) $display("FAIL len0_busy n=%0d: got %b want %b", n, busy8, n == 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    int strobes = 0;
    len8 = 8'd3; ph8 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (n == 2) len8 = 8'd7;
      tick(8'(16 + 2*n), 8'(17 + 2*n), n == 0 || n == 2, 1'b0);
      if (valid8 === 1'b1) strobes++;
      total_cnt++;
      if (done8 !== (n == 7)) $display("FAIL ign_done n=%0d: got %b want %b", n, done8, n == 7);
      else pass_cnt++;
      if (n == 7) begin
        total_cnt++;
        if ({valid8, dout8} !== {1'b1, 32'h18191A1B}) $display("FAIL ign_last: got %b/%h want 1/18191a1b", valid8, dout8);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (strobes != 3) $display("FAIL ign_strobes: got %0d want 3", strobes);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    len8 = 8'd4; ph8 = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick(8'(32 + 2*n), 8'(33 + 2*n), n == 0, 1'b0);
      if (n == 3) begin
        total_cnt++;
        if ({valid8, dout8} !== {1'b1, 32'h20212223}) $display("FAIL rst_word0: got %b/%h want 1/20212223", valid8, dout8);
        else pass_cnt++;
      end
    end
    reset = 1'b1; #1;
    total_cnt++;
    if ({dout8, valid8, busy8, done8, ris8, fal8} !== 51'd0) $display("FAIL rst_mid_clear: got %h want 0", {dout8, valid8, busy8, done8, ris8, fal8});
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick(8'h55, 8'h66, 1'b0, 1'b0);
      total_cnt++;
      if ({valid8, done8, busy8} !== 3'b000) $display("FAIL rst_quiet n=%0d: got %b want 000", n, {valid8, done8, busy8});
      else pass_cnt++;
    end
    len8 = 8'd1;
    for (int n = 0; n < 5; n++) begin
      tick(8'(48 + 2*n), 8'(49 + 2*n), n == 0, 1'b0);
      total_cnt++;
      if (valid8 !== (n == 3)) $display("FAIL rst_new_valid n=%0d: got %b want %b", n, valid8, n == 3);
      else pass_cnt++;
      if (n == 3) begin
        total_cnt++;
        if ({done8, dout8} !== {1'b1, 32'h30313233}) $display("FAIL rst_new_word: got %b/%h want 1/30313233", done8, dout8);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_gear1();
    logic exp_v;
    len4 = 8'd3; ph4 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick(8'h0A, 8'h05, 1'b0, n == 0);
      exp_v = (n >= 2 && n <= 4);
      if (n >= 1) begin
        total_cnt++;
        if ({ris4, fal4} !== 8'hA5) $display("FAIL g1_ddr n=%0d: got %h want a5", n, {ris4, fal4});
        else pass_cnt++;
      end
      total_cnt++;
      if (valid4 !== exp_v) $display("FAIL g1_valid n=%0d: got %b want %b", n, valid4, exp_v);
      else pass_cnt++;
      total_cnt++;
      if (done4 !== (n == 4)) $display("FAIL g1_done n=%0d: got %b want %b", n, done4, n == 4);
      else pass_cnt++;
      if (exp_v) begin
        total_cnt++;
        if (dout4 !== 8'hA5) $display("FAIL g1_word n=%0d: got %h want a5", n, dout4);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_max_len();
    int strobes = 0;
    int done_at = -1;
    len8 = 8'd255; ph8 = 1'b0;
    for (int n = 0; n < 520; n++) begin
      tick(8'(n), 8'(n + 128), n == 0, 1'b0);
      if (valid8 === 1'b1) strobes++;
      if (done8 === 1'b1 && done_at < 0) done_at = n;
    end
    total_cnt++;
    if (strobes != 255) $display("FAIL max_strobes: got %0d want 255", strobes);
    else pass_cnt++;
    total_cnt++;
    if (done_at != 511) $display("FAIL max_done_at: got %0d want 511", done_at);
    else pass_cnt++;
    total_cnt++;
    if (busy8 !== 1'b0) $display("FAIL max_busy_end: got %b want 0", busy8);
    else pass_cnt++;
  endtask

  initial begin
    din8 = '0; din4 = '0; start8 = 1'b0; start4 = 1'b0;
    len8 = '0; len4 = '0; ph8 = 1'b0; ph4 = 1'b0;
    test_reset();
    test_phase0();
    test_phase1();
    test_len0();
    test_busy_ignore();
    test_reset_mid();
    test_gear1();
    test_max_len();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
